// File: rtl/pattern_history_predictor.sv
// PC-indexed table of saturating counters predicting conditional-branch direction.
// Optional global-history XOR indexing is enabled by defining GSHARE_EN.
module pattern_history_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    output logic                  init_busy
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS:0]   CTR_MAX_EXT = {1'b0, {CTR_BITS{1'b1}}};
    localparam logic [CTR_BITS:0]   ONE_EXT = 1;
    localparam logic [INDEX_BITS-1:0] LAST_ENTRY = INDEX_BITS'(ENTRIES - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state, state_next;
    logic [INDEX_BITS-1:0]  sweep_cnt;
    logic [INDEX_BITS-1:0]  base_idx;
    logic [INDEX_BITS-1:0]  ghr_ext;
    logic [CTR_BITS-1:0]    table_q [ENTRIES];
    logic [CTR_BITS:0]      cur_ext, upd_ext;
    logic                   unused_pc_bits;

    assign base_idx       = fetch_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:INDEX_BITS+2], fetch_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        init_busy  = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                if (sweep_cnt == LAST_ENTRY) state_next = RUN;
            end
            RUN: init_busy = 1'b0;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                sweep_cnt <= '0;
        else if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end

    // One bit wider than the counter so saturation compares never see a wrapped value.
    always_comb begin
        cur_ext = {1'b0, table_q[upd_index]};
        upd_ext = cur_ext;
        if (upd_taken) begin
            if (cur_ext != CTR_MAX_EXT) upd_ext = cur_ext + ONE_EXT;
        end else begin
            if (cur_ext != '0) upd_ext = cur_ext - ONE_EXT;
        end
    end

    // Array is deliberately not reset; the INIT sweep fills it.
    always_ff @(posedge clk) begin
        if (state == INIT)  table_q[sweep_cnt] <= WNT;
        else if (upd_valid) table_q[upd_index] <= upd_ext[CTR_BITS-1:0];
    end

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             ghr <= '0;
        else if (state == RUN && upd_valid)  ghr <= GHR_BITS'({ghr, upd_taken});
    end

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_BITS-1:0] = ghr;
    end
`else
    logic [GHR_BITS-1:0] unused_ghr;
    assign unused_ghr = '0;
    assign ghr_ext    = '0;
`endif

    assign pred_index = base_idx ^ ghr_ext;
    assign pred_taken = (state == RUN) && table_q[pred_index][CTR_BITS-1];

endmodule

// File: tb/tb_pattern_history_predictor.sv
// Self-checking bench for pattern_history_predictor against an integer table model.
// Define GSHARE_EN for both bench and RTL to exercise the history-hashed build.
module tb_pattern_history_predictor;

    localparam int PCW = 32;
    localparam int IB  = 6;
    localparam int CB  = 2;
    localparam int GB  = 6;
    localparam int ENT = 1 << IB;
    localparam int CMAX = (1 << CB) - 1;
    localparam int HALF = 1 << (CB - 1);
    localparam int WNTV = HALF - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [PCW-1:0] fetch_pc = '0;
    logic           pred_taken;
    logic [IB-1:0]  pred_index;
    logic           upd_valid = 1'b0;
    logic [IB-1:0]  upd_index = '0;
    logic           upd_taken = 1'b0;
    logic           init_busy;

    pattern_history_predictor #(
        .PC_WIDTH(PCW), .INDEX_BITS(IB), .CTR_BITS(CB), .GHR_BITS(GB)
    ) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .pred_index(pred_index), .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_taken(upd_taken), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int  errors = 0;
    int  checks = 0;

    // Reference state: plain integers, history as an integer shift value.
    int  m_ctr [ENT];
    int  m_sweep;
    bit  m_run;
    int  m_ghr;

    function automatic int m_index(input logic [PCW-1:0] pc);
        int idx;
        idx = int'(pc / 4) % ENT;
`ifdef GSHARE_EN
        idx = idx ^ (m_ghr % (1 << GB));
`endif
        return idx;
    endfunction

    function automatic int m_pred(input logic [PCW-1:0] pc);
        if (!m_run) return 0;
        return (m_ctr[m_index(pc)] >= HALF) ? 1 : 0;
    endfunction

    task automatic m_reset();
        m_sweep = 0;
        m_run   = 1'b0;
        m_ghr   = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive after negedge, compare combinational outputs, then advance the model at posedge.
    task automatic cycle(input bit r, input bit v, input int ui, input bit t,
                         input logic [PCW-1:0] pc, input string tag);
        @(negedge clk);
        rst       = r;
        upd_valid = v;
        upd_index = IB'(ui);
        upd_taken = t;
        fetch_pc  = pc;
        if (r) m_reset();
        #1;
        check({tag, "_busy"}, int'(init_busy), m_run ? 0 : 1);
        check({tag, "_pred"}, int'(pred_taken), m_pred(pc));
        if (m_run) check({tag, "_idx"}, int'(pred_index), m_index(pc));
        @(posedge clk);
        if (r) begin
            m_reset();
        end else if (!m_run) begin
            m_ctr[m_sweep] = WNTV;
            m_sweep++;
            if (m_sweep == ENT) m_run = 1'b1;
        end else if (v) begin
            if (t) m_ctr[ui] = (m_ctr[ui] + 1 > CMAX) ? CMAX : m_ctr[ui] + 1;
            else   m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
            m_ghr = ((m_ghr * 2) + (t ? 1 : 0)) % (1 << GB);
        end
    endtask

    task automatic sweep_with_noise(input int n, input string tag);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'($urandom), int'($urandom_range(ENT - 1)), 1'($urandom),
                  $urandom, tag);
    endtask

    task automatic scan_all_pcs(input string tag);
        for (int i = 0; i < ENT; i++) begin
            cycle(1'b0, 1'b0, 0, 1'b0, PCW'(i * 4), tag);
            check({tag, "_wnt"}, int'(pred_taken), 0);
        end
    endtask

    initial begin
        int exp_seq [7];
        bit seq_t [7];
        bit seq_v [7];
        m_reset();

        // Reset held, then a full sweep with update noise that must be ignored.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, i, 1'b1, 32'h40, "rst");
        sweep_with_noise(ENT, "init");
        cycle(1'b0, 1'b0, 0, 1'b0, 32'h0, "run0");
        check("busy_fell", int'(init_busy), 0);
        scan_all_pcs("scan1");

        // Saturation trace on index 16: T,T,T,T,N,N then idle.
        exp_seq = '{0, 1, 1, 1, 1, 1, 0};
        seq_t   = '{1, 1, 1, 1, 0, 0, 0};
        seq_v   = '{1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, seq_v[i], 16, seq_t[i], 32'h40, "sat");
`ifndef GSHARE_EN
            check("sat_trace", int'(pred_taken), exp_seq[i]);
`endif
        end

        // Same-index update shows the pre-update value in that cycle.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, i < 2, 5, 1'b1, 32'h14, "nobyp");
`ifndef GSHARE_EN
            if (i == 0) check("nobyp_first", int'(pred_taken), 0);
            if (i == 2) check("nobyp_after", int'(pred_taken), 1);
`endif
        end

        // Randomized traffic in RUN.
        for (int i = 0; i < 400; i++)
            cycle(1'b0, 1'($urandom), int'($urandom_range(ENT - 1)), 1'($urandom),
                  $urandom, "rand");

        // Reset mid-sweep at entry 30 restarts the full sweep.
        cycle(1'b1, 1'b0, 0, 1'b0, 32'h0, "rst2");
        sweep_with_noise(30, "init2a");
        cycle(1'b1, 1'b1, 3, 1'b1, 32'h0, "rst3");
        sweep_with_noise(ENT, "init2b");
        cycle(1'b0, 1'b0, 0, 1'b0, 32'h40, "run2");
        check("busy_fell2", int'(init_busy), 0);
        check("ghr_clear_idx", int'(pred_index), 16);
        scan_all_pcs("scan2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
